// File: rtl/inst_rom_arb.sv
// inst_rom_arb: shares one combinational-read instruction ROM between the
// fetch port (F) and the debug/boot-verify port (D). F has fixed priority.
// Each grant returns a registered response one cycle later.
// Optional macro INST_ARB_STARVE_GUARD_EN adds a D wait counter. When the
// counter saturates at MaxWait, D is granted ahead of F for one cycle.
module inst_rom_arb #(
    parameter int unsigned AddrW   = 32,
    parameter int unsigned DataW   = 32,
    parameter int unsigned MaxWait = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             f_req_i,
    input  logic [AddrW-1:0] f_addr_i,
    output logic             f_gnt_o,
    output logic             f_valid_o,
    output logic [DataW-1:0] f_inst_o,
    output logic             f_err_o,
    input  logic             d_req_i,
    input  logic [AddrW-1:0] d_addr_i,
    output logic             d_gnt_o,
    output logic             d_valid_o,
    output logic [DataW-1:0] d_inst_o,
    output logic             d_err_o,
    output logic             rom_ce_o,
    output logic [AddrW-1:0] rom_addr_o,
    input  logic [DataW-1:0] rom_inst_i
);

    logic             force_d;
    logic             f_gnt, d_gnt;
    logic             f_mis, d_mis;
    logic             f_valid_q, f_valid_d, d_valid_q, d_valid_d;
    logic             f_err_q, f_err_d, d_err_q, d_err_d;
    logic [DataW-1:0] f_inst_q, f_inst_d, d_inst_q, d_inst_d;

`ifdef INST_ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(MaxWait + 1);
    logic [CntW-1:0] wait_q, wait_d;

    // D wait counter: counts denied D cycles, saturates, clears on grant or withdrawal
    always_comb begin
        wait_d = wait_q;
        if (!d_req_i || d_gnt) begin
            wait_d = '0;
        end else if (wait_q != CntW'(MaxWait)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Gate with d_req so a withdrawn D request never steals F's slot
    assign force_d = d_req_i && (wait_q == CntW'(MaxWait));
`else
    assign force_d = 1'b0;
`endif

    // Arbitration. Reset gates the grants so the ROM drive drops asynchronously.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_ni) begin
            if (f_req_i && !force_d) begin
                f_gnt = 1'b1;
            end else if (d_req_i) begin
                d_gnt = 1'b1;
            end
        end
    end

    assign f_gnt_o    = f_gnt;
    assign d_gnt_o    = d_gnt;
    assign rom_ce_o   = f_gnt | d_gnt;
    assign rom_addr_o = f_gnt ? f_addr_i : (d_gnt ? d_addr_i : '0);

    assign f_mis = |f_addr_i[1:0];
    assign d_mis = |d_addr_i[1:0];

    // Response next-state. Misaligned reads return zero data with err set.
    always_comb begin
        f_valid_d = f_gnt;
        f_err_d   = f_gnt & f_mis;
        f_inst_d  = f_inst_q;
        d_valid_d = d_gnt;
        d_err_d   = d_gnt & d_mis;
        d_inst_d  = d_inst_q;
        if (f_gnt) begin
            f_inst_d = f_mis ? '0 : rom_inst_i;
        end
        if (d_gnt) begin
            d_inst_d = d_mis ? '0 : rom_inst_i;
        end
    end

    // Response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_valid_q <= 1'b0;
            f_err_q   <= 1'b0;
            f_inst_q  <= '0;
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;
            d_inst_q  <= '0;
        end else begin
            f_valid_q <= f_valid_d;
            f_err_q   <= f_err_d;
            f_inst_q  <= f_inst_d;
            d_valid_q <= d_valid_d;
            d_err_q   <= d_err_d;
            d_inst_q  <= d_inst_d;
        end
    end

    assign f_valid_o = f_valid_q;
    assign f_err_o   = f_err_q;
    assign f_inst_o  = f_inst_q;
    assign d_valid_o = d_valid_q;
    assign d_err_o   = d_err_q;
    assign d_inst_o  = d_inst_q;

endmodule

// File: tb/tb_inst_rom_arb.sv
// tb_inst_rom_arb: scoreboard bench for inst_rom_arb with a small ROM model.
// Build with INST_ARB_STARVE_GUARD_EN defined to exercise the forced-grant path.
module tb_inst_rom_arb;

    localparam int unsigned MaxWait = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, d_req;
    logic [31:0] f_addr, d_addr;
    logic        f_gnt, d_gnt, f_valid, d_valid, f_err, d_err;
    logic [31:0] f_inst, d_inst;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;

    logic [31:0] rom_mem [16];
    resp_t       f_q[$];
    resp_t       d_q[$];
    logic [31:0] last_f, last_d;
    int          mw_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_inst = rom_ce ? rom_mem[rom_addr[5:2]] : 32'h0;

    inst_rom_arb #(
        .AddrW  (32),
        .DataW  (32),
        .MaxWait(MaxWait)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .f_req_i   (f_req),
        .f_addr_i  (f_addr),
        .f_gnt_o   (f_gnt),
        .f_valid_o (f_valid),
        .f_inst_o  (f_inst),
        .f_err_o   (f_err),
        .d_req_i   (d_req),
        .d_addr_i  (d_addr),
        .d_gnt_o   (d_gnt),
        .d_valid_o (d_valid),
        .d_inst_o  (d_inst),
        .d_err_o   (d_err),
        .rom_ce_o  (rom_ce),
        .rom_addr_o(rom_addr),
        .rom_inst_i(rom_inst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare registered responses against the scoreboard after an edge
    task automatic check_resp();
        resp_t r;
        if (f_q.size() > 0) begin
            r = f_q.pop_front();
            check("f_valid", 32'(f_valid), 32'd1);
            check("f_inst", f_inst, r.inst);
            check("f_err", 32'(f_err), 32'(r.err));
            last_f = r.inst;
        end else begin
            check("f_valid_idle", 32'(f_valid), 32'd0);
            check("f_err_idle", 32'(f_err), 32'd0);
            check("f_inst_hold", f_inst, last_f);
        end
        if (d_q.size() > 0) begin
            r = d_q.pop_front();
            check("d_valid", 32'(d_valid), 32'd1);
            check("d_inst", d_inst, r.inst);
            check("d_err", 32'(d_err), 32'(r.err));
            last_d = r.inst;
        end else begin
            check("d_valid_idle", 32'(d_valid), 32'd0);
            check("d_err_idle", 32'(d_err), 32'd0);
            check("d_inst_hold", d_inst, last_d);
        end
    endtask

    // One clock cycle: drive requests, check grants and ROM drive, push expectations
    task automatic step(input logic fr, input logic [31:0] fa, input logic dr,
                        input logic [31:0] da, output logic gf, output logic gd);
        logic        frc, ef, ed;
        logic [31:0] ea;
        resp_t       r;
        f_req  = fr;
        f_addr = fa;
        d_req  = dr;
        d_addr = da;
        #1;
        frc = 1'b0;
`ifdef INST_ARB_STARVE_GUARD_EN
        frc = dr && (mw_cnt == int'(MaxWait));
`endif
        ef = fr && !frc;
        ed = dr && !ef;
        ea = ef ? fa : (ed ? da : 32'h0);
        gf = f_gnt;
        gd = d_gnt;
        check("f_gnt", 32'(f_gnt), 32'(ef));
        check("d_gnt", 32'(d_gnt), 32'(ed));
        check("rom_ce", 32'(rom_ce), 32'(ef | ed));
        check("rom_addr", rom_addr, ea);
        if (ef) begin
            r.err  = |fa[1:0];
            r.inst = r.err ? 32'h0 : rom_mem[fa[5:2]];
            f_q.push_back(r);
        end
        if (ed) begin
            r.err  = |da[1:0];
            r.inst = r.err ? 32'h0 : rom_mem[da[5:2]];
            d_q.push_back(r);
        end
        if (ed || !dr) mw_cnt = 0;
        else if (mw_cnt < int'(MaxWait)) mw_cnt++;
        @(posedge clk);
        #1;
        check_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gf, gd;
        int   first_d, d_cnt;
        logic dr;

        for (int i = 0; i < 16; i++) rom_mem[i] = 32'hA500_0000 + 32'(i * 32'h0101_0011);
        rom_mem[2] = 32'h2408_0001;
        last_f = 32'h0;
        last_d = 32'h0;
        mw_cnt = 0;

        // Reset state
        rst_n  = 1'b0;
        f_req  = 1'b0;
        d_req  = 1'b0;
        f_addr = 32'h0;
        d_addr = 32'h0;
        #12;
        check("rst_f_valid", 32'(f_valid), 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_f_inst", f_inst, 32'd0);
        check("rst_rom_ce", 32'(rom_ce), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single fetch of word 2
        step(1'b1, 32'h8, 1'b0, 32'h0, gf, gd);

        // Reset asserted while a response is showing, F still requesting
        step(1'b1, 32'h4, 1'b0, 32'h0, gf, gd);
        rst_n = 1'b0;
        #1;
        check("mrst_f_valid", 32'(f_valid), 32'd0);
        check("mrst_f_inst", f_inst, 32'd0);
        check("mrst_f_err", 32'(f_err), 32'd0);
        check("mrst_f_gnt", 32'(f_gnt), 32'd0);
        check("mrst_rom_ce", 32'(rom_ce), 32'd0);
        check("mrst_rom_addr", rom_addr, 32'd0);
        f_req = 1'b0;
        f_q.delete();
        d_q.delete();
        last_f = 32'h0;
        last_d = 32'h0;
        mw_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 32'h0, gf, gd);

        // Misaligned debug read, then an aligned one
        step(1'b0, 32'h0, 1'b1, 32'h6, gf, gd);
        step(1'b0, 32'h0, 1'b1, 32'h14, gf, gd);
        step(1'b0, 32'h0, 1'b0, 32'h0, gf, gd);

        // Back-to-back fetches
        step(1'b1, 32'h0, 1'b0, 32'h0, gf, gd);
        step(1'b1, 32'h4, 1'b0, 32'h0, gf, gd);
        step(1'b1, 32'h8, 1'b0, 32'h0, gf, gd);
        step(1'b0, 32'h0, 1'b0, 32'h0, gf, gd);

        // Contention: F held high, D requests from cycle 0 until granted
        first_d = -1;
        d_cnt   = 0;
        dr      = 1'b1;
`ifdef INST_ARB_STARVE_GUARD_EN
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 32'(c * 4), dr, 32'h1C, gf, gd);
            if (gd && first_d < 0) first_d = c;
            if (c == 9) check("f_regrant", 32'(gf), 32'd1);
            if (gd) dr = 1'b0;
        end
        check("d_first_gnt", 32'(first_d), 32'd8);
`else
        for (int c = 0; c < 100; c++) begin
            step(1'b1, 32'((c % 16) * 4), dr, 32'h1C, gf, gd);
            if (gd) d_cnt++;
        end
        check("d_starved", 32'(d_cnt), 32'd0);
`endif
        step(1'b0, 32'h0, 1'b0, 32'h0, gf, gd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_rom_arb.md
# inst_rom_arb

Two-requester arbiter in front of the single-ported, combinational-read instruction ROM.
- Shares the ROM between the pipeline fetch stage (port F) and the debug/boot-verify read port (port D).
- Drives the ROM chip enable and word address.
- Returns each read as a registered response one cycle after grant.
- Sits between the PC/IF logic and the instruction ROM.

## Interface
- `ADDR_W`, 32, byte-address width of both requesters.
- `DATA_W`, 32, instruction word width.
- `MAX_WAIT`, 8, cycles a pending D request may be denied before a forced grant (≥1).
- `clk  in  1  system clock, rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `f_req  in  1  fetch read request`
- `f_addr  in  ADDR_W  fetch byte address`
- `f_gnt  out  1  fetch granted this cycle (combinational)`
- `f_valid  out  1  fetch response valid (one-cycle pulse)`
- `f_inst  out  DATA_W  fetch response data`
- `f_err  out  1  fetch response was misaligned; qualified by f_valid`
- `d_req`, `d_addr`, `d_gnt`, `d_valid`, `d_inst`, `d_err`: same as the F signals, for the debug port.
- `rom_ce  out  1  ROM chip enable, active-high`
- `rom_addr  out  ADDR_W  byte address to ROM; ROM indexes by word`
- `rom_inst  in  DATA_W  ROM read data, combinational from rom_ce/rom_addr`

## Operation
- **Requester rules.** A requester raises `*_req` with a stable `*_addr` and holds both until it sees `*_gnt`=1 in the same cycle. The request is consumed on that edge. Deasserting before grant is legal and withdraws the request.
- **Arbitration.** Combinational, once per cycle.
  - F wins whenever `f_req`=1, unless a forced grant is active.
  - D wins when `f_req`=0 and `d_req`=1.
  - At most one `*_gnt` is high in any cycle.
- **ROM drive.**
  - While a grant is active: `rom_ce`=1 and `rom_addr` = winner's address.
  - With no grant: `rom_ce`=0 and `rom_addr`=0.
- **Response.**
  - On the granting edge, `rom_inst` is captured into the winner's `*_inst` register and the winner's `*_valid` is set for exactly one cycle.
  - `*_inst` holds its last value until the next response of that port.
- **Misalignment.** If the granted address has `[1:0]` ≠ 0:
  - the ROM is still enabled;
  - the captured data is forced to 0;
  - `*_err`=1 in the same cycle as `*_valid`.
  - `*_err` is 0 whenever `*_valid`=0.
- **Back-to-back.** A port may be granted on consecutive cycles and then receives consecutive valid pulses. No bubble is inserted between ports.
- **Reset (mid-operation included).** All outputs go to 0 immediately: `*_valid`, `*_err`, `*_inst`, `rom_ce`, `rom_addr`. Any in-flight response is discarded. The starvation counter clears.

## Timing
- Grant latency: 0 cycles (same cycle as request, if the requester wins).
- Response latency: `*_valid` rises 1 cycle after the granting cycle.
- Peak throughput: one response per cycle, total across both ports.
- Simultaneous `f_req`/`d_req` with no forced grant: F granted, D waits; the D counter increments.

## Configuration
- `INST_ARB_STARVE_GUARD_EN` defined:
  - A wait counter (width ⌈log2(MAX_WAIT+1)⌉) increments each cycle `d_req`=1 and `d_gnt`=0, saturating at `MAX_WAIT`.
  - It clears when `d_gnt`=1 or `d_req`=0.
  - When the counter equals `MAX_WAIT`, D is granted and F is denied that cycle, even if `f_req`=1.
- `INST_ARB_STARVE_GUARD_EN` undefined:
  - Strict fixed priority; no counter is instantiated.
  - D can starve indefinitely while `f_req` stays high.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-response → all outputs 0 asynchronously; after release with no requests, `rom_ce`=0.
- **Single fetch.** `f_req`=1, `f_addr`=0x0000_0008, ROM word 2 = 0x2408_0001 → `f_gnt`=1 in cycle 0; `f_valid`=1, `f_inst`=0x2408_0001, `f_err`=0 in cycle 1.
- **Contention, guard defined.** `MAX_WAIT`=8; `f_req` held high and `d_req` rises at cycle 0 → `d_gnt` first at cycle 8 with `f_gnt`=0 that cycle; `d_valid` at cycle 9; F regranted at cycle 9.
- **Contention, guard undefined.** Same stimulus for 100 cycles → `d_gnt` never asserts; `f_valid` high on every cycle from 1 to 100.
- **Misaligned.** `d_req` alone with `d_addr`=0x0000_0006 → `d_gnt`=1; next cycle `d_valid`=1, `d_err`=1, `d_inst`=0.
- **Back-to-back.** F addresses 0x0, 0x4, 0x8 on consecutive cycles → three consecutive `f_valid` pulses carrying ROM words 0, 1, 2 in order.
